coeff_loader: RTL and testbench
===============================

COEFF_LOADER -- requirements
Module: coeff_loader

Interface
REQ-001 The parameter NBITS SHALL default to 2 and SHALL set the width of each real and imaginary part.
REQ-002 The parameter N SHALL default to 8 and SHALL set the number of coefficient slots per set (N >= 2).
REQ-003 The port clk SHALL be an input, 1 bit wide, and SHALL be the clock; all state updates occur on its rising edge.
REQ-004 The port rst SHALL be an input, 1 bit wide, and SHALL be the reset: synchronous, active-low.
REQ-005 The port in_data SHALL be an input, 2*NBITS bits wide, carrying one coefficient word.
REQ-006 The port in_valid SHALL be an input, 1 bit wide, indicating that in_data is valid.
REQ-007 The port in_last SHALL be an input, 1 bit wide, marking the final word of a set.
REQ-008 The port in_ready SHALL be an output, 1 bit wide, indicating that the block accepts a word this cycle.
REQ-009 The port consume SHALL be an input, 1 bit wide, by which downstream acknowledges that it has taken the active set.
REQ-010 The port coeff_data SHALL be an output, N*2*NBITS bits wide, carrying the active parallel coefficient set.
REQ-011 The port coeff_valid SHALL be an output, 1 bit wide, indicating that coeff_data holds an unconsumed set.
REQ-012 The port fill_level SHALL be an output, $clog2(N)+1 bits wide, giving the number of words currently held in the shadow buffer.
REQ-013 The port err_len SHALL be an output, 1 bit wide, a one-cycle pulse on a set-length violation.

Function
REQ-014 The block SHALL be the serial-to-parallel inverse of the coefficient streamer: it packs streamed words into one N-slot set.
REQ-015 A word SHALL be accepted on a clock edge where in_valid=1 and in_ready=1.
REQ-016 Word k of a set (k=0..N-1) SHALL be written to shadow slot k.
REQ-017 Slot k SHALL map to coeff_data[N*2*NBITS-1-k*2*NBITS -: 2*NBITS], so slot 0 occupies the MSBs.
REQ-018 The block SHALL double-buffer: one shadow buffer being filled and one active register driving coeff_data.
REQ-019 The FSM SHALL have two states, LOAD and SWAP, and SHALL reset to LOAD.
REQ-020 in_ready SHALL equal (state==LOAD) AND rst, and SHALL be combinational from registered state.
REQ-021 In LOAD, on acceptance with wr_idx < N-1 and in_last=0, the block SHALL store the word and increment wr_idx.
REQ-022 In LOAD, on acceptance with wr_idx < N-1 and in_last=1, the block SHALL discard the word and the partial set, reset wr_idx to 0, pulse err_len, and stay in LOAD.
REQ-023 In LOAD, on acceptance with wr_idx == N-1, the block SHALL store the word, reset wr_idx to 0, and go to SWAP.
REQ-024 If in_last=0 on that final word, the block SHALL pulse err_len and SHALL still commit the set.
REQ-025 In SWAP, if coeff_valid=0 or consume=1, then at that edge the block SHALL copy shadow to coeff_data, set coeff_valid=1, and return to LOAD.
REQ-026 In SWAP otherwise, the block SHALL hold state with in_ready=0 (backpressure).
REQ-027 Latency: if the final word is accepted on edge E, coeff_valid SHALL rise after edge E+1 at the earliest.
REQ-028 In LOAD, consume=1 while coeff_valid=1 SHALL clear coeff_valid at that edge, and coeff_data SHALL retain its value.
REQ-029 consume SHALL be ignored while coeff_valid=0.
REQ-030 A simultaneous swap and consume in SWAP SHALL result in coeff_valid=1 with the new set (the swap wins).
REQ-031 fill_level SHALL equal wr_idx in LOAD and SHALL equal N in SWAP.
REQ-032 err_len SHALL be high for exactly one cycle after each violation and low otherwise.
REQ-033 The shadow contents of unused slots SHALL NOT be cleared by a discarded partial set; they are overwritten by the next set.

Reset
REQ-034 While rst=0 at an edge, the block SHALL set state=LOAD, wr_idx=0, coeff_data=0, coeff_valid=0, err_len=0, fill_level=0, and shadow=0.
REQ-035 in_ready SHALL be 0 whenever rst=0.
REQ-036 A reset asserted mid-set or during SWAP SHALL abandon all pending data with no commit.

Verification (N=8, NBITS=2)
REQ-037 Scenario 1: stream 0x0..0x7 with in_last on the 8th word, consume tied to 0 -> coeff_valid=1 two edges after the last accept; coeff_data=0x01234567.
REQ-038 Scenario 2: with set 1 unconsumed, stream a second set 0xF..0x8 -> in_ready=0 after its last word and fill_level=8; after pulsing consume once, coeff_data=0xFEDCBA98, coeff_valid=1, and in_ready=1.
REQ-039 Scenario 3: assert in_last on the 3rd word -> err_len pulses once, fill_level=0, coeff_valid unchanged; a following full set commits correctly.
REQ-040 Scenario 4: send 8 words with in_last=0 throughout -> err_len pulses once and the set still commits.
REQ-041 Scenario 5: with coeff_valid=1 and no new set in flight, pulse consume for one cycle -> coeff_valid=0 and coeff_data holds its value.
REQ-042 Scenario 6: drop rst low after 5 words, then release and send a full set -> all outputs are 0 during reset and only the new set appears on coeff_data.

Source files
------------

// File: rtl/coeff_loader.sv
// Serial-to-parallel coefficient loader: packs N streamed words into a shadow set,
// then swaps it into the active register that drives coeff_data.
//
// state | meaning
// LOAD  | accepting words into the shadow buffer; consume may retire the active set
// SWAP  | shadow full; waiting for the active set to be free before copying it over
module coeff_loader #(
  parameter int NBITS = 2,
  parameter int N     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2*NBITS-1:0]      in_data,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  input  logic                    consume,
  output logic [N*2*NBITS-1:0]    coeff_data,
  output logic                    coeff_valid,
  output logic [$clog2(N):0]      fill_level,
  output logic                    err_len
);

  localparam int W  = 2 * NBITS;
  localparam int IW = $clog2(N) + 1;

  typedef enum logic {LOAD = 1'b0, SWAP = 1'b1} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   wr_idx, wr_idx_nx;
  logic [W-1:0]    shadow [N];
  logic [N*W-1:0]  shadow_flat;
  logic            accept, last_slot, shadow_we, swap, err_nx, valid_nx;

  always_comb begin
    in_ready   = (state == LOAD) & rst;
    accept     = in_valid & in_ready;
    last_slot  = (wr_idx == IW'(N - 1));
    fill_level = (state == SWAP) ? IW'(N) : wr_idx;
  end

  // Slot 0 lands in the MSBs of the parallel word.
  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < N; k++)
      shadow_flat[N*W-1-k*W -: W] = shadow[k];
  end

  always_comb begin
    state_nx  = state;
    wr_idx_nx = wr_idx;
    shadow_we = 1'b0;
    swap      = 1'b0;
    err_nx    = 1'b0;
    valid_nx  = coeff_valid;
    case (state)
      LOAD: begin
        if (consume && coeff_valid) valid_nx = 1'b0;
        if (accept) begin
          if (last_slot) begin
            shadow_we = 1'b1;
            wr_idx_nx = '0;
            err_nx    = ~in_last;
            state_nx  = SWAP;
          end else if (in_last) begin
            // Short set: drop it; stale slots are simply overwritten by the next set.
            wr_idx_nx = '0;
            err_nx    = 1'b1;
          end else begin
            shadow_we = 1'b1;
            wr_idx_nx = wr_idx + IW'(1);
          end
        end
      end
      SWAP: begin
        // A consume arriving with the swap is absorbed: the new set stays valid.
        if (!coeff_valid || consume) begin
          swap     = 1'b1;
          valid_nx = 1'b1;
          state_nx = LOAD;
        end
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= LOAD;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_idx      <= '0;
      coeff_data  <= '0;
      coeff_valid <= 1'b0;
      err_len     <= 1'b0;
      for (int k = 0; k < N; k++) shadow[k] <= '0;
    end else begin
      wr_idx      <= wr_idx_nx;
      coeff_valid <= valid_nx;
      err_len     <= err_nx;
      if (swap) coeff_data <= shadow_flat;
      for (int k = 0; k < N; k++)
        if (shadow_we && wr_idx == IW'(k)) shadow[k] <= in_data;
    end
  end

endmodule

// File: tb/tb_coeff_loader.sv
// Self-checking bench for coeff_loader (N=8, NBITS=2): scenario tasks with inline
// checks plus a scoreboard of committed sets compared whenever a new set appears.
module tb_coeff_loader;

  localparam int NBITS = 2;
  localparam int N     = 8;
  localparam int W     = 2 * NBITS;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic             consume;
  logic [N*W-1:0]   coeff_data;
  logic             coeff_valid;
  logic [3:0]       fill_level;
  logic             err_len;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [N*W-1:0] exp_q [$];
  logic [N*W-1:0] prev_data = '0;
  logic           prev_valid = 1'b0;

  coeff_loader #(.NBITS(NBITS), .N(N)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .consume(consume), .coeff_data(coeff_data),
    .coeff_valid(coeff_valid), .fill_level(fill_level), .err_len(err_len)
  );

  always #5 clk = ~clk;

  // Scoreboard: a new set shows up as valid rising or active data changing while valid.
  always @(negedge clk) begin
    if (coeff_valid === 1'b1 && (prev_valid !== 1'b1 || coeff_data !== prev_data)) begin
      chk_cnt++;
      if (exp_q.size() == 0)
        $display("FAIL sb_commit: unexpected set %h, none pending", coeff_data);
      else begin
        logic [N*W-1:0] e;
        e = exp_q.pop_front();
        if (coeff_data !== e) $display("FAIL sb_commit: got %h want %h", coeff_data, e);
        else pass_cnt++;
      end
    end
    prev_valid = coeff_valid;
    prev_data  = coeff_data;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d, input logic last);
    int n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk_cnt++;
    if (in_ready !== 1'b1) $display("FAIL send_wait: in_ready %b want 1 within 50 cycles", in_ready);
    else pass_cnt++;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_set(input logic [N*W-1:0] set, input logic with_last);
    for (int k = 0; k < N; k++)
      send_word(set[N*W-1-k*W -: W], with_last && (k == N - 1));
  endtask

  task automatic pulse_consume();
    consume = 1'b1;
    tick();
    consume = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; consume = 1'b0;
    repeat (3) tick();
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_ready: got %b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (coeff_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", coeff_valid); else pass_cnt++;
    chk_cnt++; if (coeff_data !== '0) $display("FAIL rst_data: got %h want 0", coeff_data); else pass_cnt++;
    chk_cnt++; if (fill_level !== 4'd0) $display("FAIL rst_fill: got %0d want 0", fill_level); else pass_cnt++;
    chk_cnt++; if (err_len !== 1'b0) $display("FAIL rst_err: got %b want 0", err_len); else pass_cnt++;
    rst = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_basic();
    exp_q.push_back(32'h0123_4567);
    send_set(32'h0123_4567, 1'b1);
    chk_cnt++; if (coeff_valid !== 1'b0) $display("FAIL s1_latency: valid %b want 0 one edge after last", coeff_valid); else pass_cnt++;
    chk_cnt++; if (fill_level !== 4'd8) $display("FAIL s1_fill_swap: got %0d want 8", fill_level); else pass_cnt++;
    chk_cnt++; if (err_len !== 1'b0) $display("FAIL s1_err: got %b want 0", err_len); else pass_cnt++;
    tick();
    chk_cnt++; if (coeff_valid !== 1'b1) $display("FAIL s1_valid: got %b want 1", coeff_valid); else pass_cnt++;
    chk_cnt++; if (coeff_data !== 32'h0123_4567) $display("FAIL s1_data: got %h want 01234567", coeff_data); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL s1_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(32'hFEDC_BA98);
    send_set(32'hFEDC_BA98, 1'b1);
    repeat (2) tick();
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL s2_backpressure: in_ready %b want 0", in_ready); else pass_cnt++;
    chk_cnt++; if (fill_level !== 4'd8) $display("FAIL s2_fill: got %0d want 8", fill_level); else pass_cnt++;
    chk_cnt++; if (coeff_data !== 32'h0123_4567) $display("FAIL s2_hold_old: got %h want 01234567", coeff_data); else pass_cnt++;
    pulse_consume();
    chk_cnt++; if (coeff_data !== 32'hFEDC_BA98) $display("FAIL s2_data: got %h want fedcba98", coeff_data); else pass_cnt++;
    chk_cnt++; if (coeff_valid !== 1'b1) $display("FAIL s2_valid: got %b want 1", coeff_valid); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL s2_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_short_set();
    send_word(4'h1, 1'b0);
    send_word(4'h2, 1'b0);
    send_word(4'h3, 1'b1);
    chk_cnt++; if (err_len !== 1'b1) $display("FAIL s3_err_pulse: got %b want 1", err_len); else pass_cnt++;
    chk_cnt++; if (fill_level !== 4'd0) $display("FAIL s3_fill: got %0d want 0", fill_level); else pass_cnt++;
    chk_cnt++; if (coeff_valid !== 1'b1) $display("FAIL s3_valid_kept: got %b want 1", coeff_valid); else pass_cnt++;
    chk_cnt++; if (coeff_data !== 32'hFEDC_BA98) $display("FAIL s3_data_kept: got %h want fedcba98", coeff_data); else pass_cnt++;
    tick();
    chk_cnt++; if (err_len !== 1'b0) $display("FAIL s3_err_once: got %b want 0", err_len); else pass_cnt++;
    exp_q.push_back(32'h1357_9BDF);
    send_set(32'h1357_9BDF, 1'b1);
    tick();
    chk_cnt++; if (coeff_data !== 32'hFEDC_BA98) $display("FAIL s3_wait_swap: got %h want fedcba98", coeff_data); else pass_cnt++;
    pulse_consume();
    chk_cnt++; if (coeff_data !== 32'h1357_9BDF) $display("FAIL s3_next_set: got %h want 13579bdf", coeff_data); else pass_cnt++;
    chk_cnt++; if (coeff_valid !== 1'b1) $display("FAIL s3_next_valid: got %b want 1", coeff_valid); else pass_cnt++;
  endtask

  task automatic test_consume();
    pulse_consume();
    chk_cnt++; if (coeff_valid !== 1'b0) $display("FAIL s5_cleared: got %b want 0", coeff_valid); else pass_cnt++;
    chk_cnt++; if (coeff_data !== 32'h1357_9BDF) $display("FAIL s5_data_hold: got %h want 13579bdf", coeff_data); else pass_cnt++;
    pulse_consume();
    chk_cnt++; if (coeff_valid !== 1'b0) $display("FAIL s5_ignored: got %b want 0", coeff_valid); else pass_cnt++;
    chk_cnt++; if (coeff_data !== 32'h1357_9BDF) $display("FAIL s5_data_hold2: got %h want 13579bdf", coeff_data); else pass_cnt++;
  endtask

  task automatic test_no_last();
    exp_q.push_back(32'h2468_ACE0);
    send_set(32'h2468_ACE0, 1'b0);
    chk_cnt++; if (err_len !== 1'b1) $display("FAIL s4_err_pulse: got %b want 1", err_len); else pass_cnt++;
    chk_cnt++; if (coeff_valid !== 1'b0) $display("FAIL s4_latency: got %b want 0", coeff_valid); else pass_cnt++;
    tick();
    chk_cnt++; if (err_len !== 1'b0) $display("FAIL s4_err_once: got %b want 0", err_len); else pass_cnt++;
    chk_cnt++; if (coeff_valid !== 1'b1) $display("FAIL s4_valid: got %b want 1", coeff_valid); else pass_cnt++;
    chk_cnt++; if (coeff_data !== 32'h2468_ACE0) $display("FAIL s4_data: got %h want 2468ace0", coeff_data); else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    pulse_consume();
    for (int k = 0; k < 5; k++) send_word(4'h9, 1'b0);
    chk_cnt++; if (fill_level !== 4'd5) $display("FAIL s6_fill_partial: got %0d want 5", fill_level); else pass_cnt++;
    rst = 1'b0;
    #1;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL s6_ready_in_rst: got %b want 0", in_ready); else pass_cnt++;
    repeat (2) tick();
    chk_cnt++; if (coeff_data !== '0) $display("FAIL s6_data_rst: got %h want 0", coeff_data); else pass_cnt++;
    chk_cnt++; if (coeff_valid !== 1'b0) $display("FAIL s6_valid_rst: got %b want 0", coeff_valid); else pass_cnt++;
    chk_cnt++; if (fill_level !== 4'd0) $display("FAIL s6_fill_rst: got %0d want 0", fill_level); else pass_cnt++;
    chk_cnt++; if (err_len !== 1'b0) $display("FAIL s6_err_rst: got %b want 0", err_len); else pass_cnt++;
    rst = 1'b1;
    #1;
    exp_q.push_back(32'h7654_3210);
    send_set(32'h7654_3210, 1'b1);
    tick();
    chk_cnt++; if (coeff_data !== 32'h7654_3210) $display("FAIL s6_new_set: got %h want 76543210", coeff_data); else pass_cnt++;
    chk_cnt++; if (coeff_valid !== 1'b1) $display("FAIL s6_valid: got %b want 1", coeff_valid); else pass_cnt++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_set();
    test_consume();
    test_no_last();
    test_mid_reset();
    repeat (2) tick();
    chk_cnt++;
    if (exp_q.size() != 0) $display("FAIL sb_drain: %0d sets never committed, want 0", exp_q.size());
    else pass_cnt++;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
